// File: rtl/completion_buffer_pkg.sv
// Shared types for the completion buffer: word and FU enums, entry index and entry payload.
// Optional feature macro: CB_EXCEPTION_EN adds a per-entry exception bit.
package completion_buffer_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned RD_W         = 5;
  localparam int unsigned NUM_CB_ENTRY = 16;
  localparam int unsigned CB_IDX_W     = $clog2(NUM_CB_ENTRY);
  localparam int unsigned NUM_WB       = 4;

  typedef logic [XLEN-1:0] word_t;

  // Writeback port numbering; lower value has higher priority on a collision
  typedef enum logic [1:0] {
    ARITH_S     = 2'd0,
    MUL_S       = 2'd1,
    DIV_S       = 2'd2,
    LOADSTORE_S = 2'd3
  } scalar_fu_t;

  typedef logic [CB_IDX_W-1:0] cb_index_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
`ifdef CB_EXCEPTION_EN
    logic            exc;
`endif
    logic            wen;
    logic [RD_W-1:0] rd;
    word_t           data;
  } cb_entry_t;

endpackage

// File: rtl/completion_buffer.sv
// In-order retirement buffer: dispatch allocates at tail, FUs write back by index out of order,
// head retires to the register file in program order, at most one entry per cycle.
// Optional feature macro: CB_EXCEPTION_EN (exception-holding head entry).
module completion_buffer
  import completion_buffer_pkg::*;
#(
  parameter  int unsigned NUM_ENTRY = NUM_CB_ENTRY,
  localparam int unsigned IDX_W     = $clog2(NUM_ENTRY)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             flush,
  input  logic                             alloc_valid,
  input  logic [RD_W-1:0]                  alloc_rd,
  input  logic                             alloc_wen,
  output logic [IDX_W-1:0]                 alloc_index,
  output logic                             cb_full,
  output logic                             cb_empty,
  output logic [IDX_W:0]                   cb_count,
  input  logic [NUM_WB-1:0]                wb_valid,
  input  logic [NUM_WB-1:0][IDX_W-1:0]     wb_index,
  input  logic [NUM_WB-1:0][XLEN-1:0]      wb_data,
`ifdef CB_EXCEPTION_EN
  input  logic [NUM_WB-1:0]                wb_exception,
  output logic                             exc_valid,
  output logic [IDX_W-1:0]                 exc_index,
`endif
  output logic                             rf_wen,
  output logic [RD_W-1:0]                  rf_rd,
  output logic [XLEN-1:0]                  rf_wdata,
  output logic                             retire_valid
);

  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  cb_entry_t         r_entry [NUM_ENTRY];

  logic [IDX_W-1:0]  w_head_idx;
  logic [IDX_W-1:0]  w_tail_idx;
  cb_entry_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_alloc;
  logic              w_head_done;
  logic              w_retire;
  logic              w_wb_collision;
  logic [NUM_ENTRY-1:0] w_wb_hit;
  logic [XLEN-1:0]   w_wb_data [NUM_ENTRY];
`ifdef CB_EXCEPTION_EN
  logic [NUM_ENTRY-1:0] w_wb_exc;
  logic              w_head_exc;
`endif

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_head     = r_entry[w_head_idx];

  // Occupancy flags from registered pointers, i.e. before this cycle's retire
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_alloc = alloc_valid && !w_full;

  assign alloc_index = w_tail_idx;
  assign cb_full     = w_full;
  assign cb_empty    = w_empty;
  assign cb_count    = r_tail - r_head;

  // Per-entry writeback select; the lowest-numbered matching port is applied last and wins
  for (genvar e = 0; e < NUM_ENTRY; e++) begin : g_wb_sel
    logic            w_hit;
    logic [XLEN-1:0] w_data;
`ifdef CB_EXCEPTION_EN
    logic            w_exc;
`endif
    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
`ifdef CB_EXCEPTION_EN
      w_exc  = 1'b0;
`endif
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (wb_valid[p] && (wb_index[p] == IDX_W'(e))) begin
          w_hit  = 1'b1;
          w_data = wb_data[p];
`ifdef CB_EXCEPTION_EN
          w_exc  = wb_exception[p];
`endif
        end
      end
    end
    assign w_wb_hit[e]  = w_hit;
    assign w_wb_data[e] = w_data;
`ifdef CB_EXCEPTION_EN
    assign w_wb_exc[e]  = w_exc;
`endif
  end

  // Detect two writeback ports targeting the same entry in one cycle (protocol error)
  always_comb begin
    w_wb_collision = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      for (int j = i + 1; j < NUM_WB; j++) begin
        if (wb_valid[i] && wb_valid[j] && (wb_index[i] == wb_index[j])) begin
          w_wb_collision = 1'b1;
        end
      end
    end
  end

  a_wb_collision : assert property (@(posedge CLK) disable iff (RST) !w_wb_collision)
    else $warning("completion_buffer: two writeback ports target the same entry");

  // Head entry finished; with exceptions enabled a faulting head parks instead of retiring
  assign w_head_done = w_head.valid && w_head.ready && !flush;
`ifdef CB_EXCEPTION_EN
  assign w_head_exc = w_head.exc;
  assign w_retire   = w_head_done && !w_head_exc;
  assign exc_valid  = w_head_done && w_head_exc;
  assign exc_index  = exc_valid ? w_head_idx : '0;
`else
  assign w_retire   = w_head_done;
`endif

  // Register-file write port driven from the head entry, zeroed when nothing retires
  always_comb begin
    retire_valid = w_retire;
    rf_wen       = 1'b0;
    rf_rd        = '0;
    rf_wdata     = '0;
    if (w_retire) begin
      rf_wen   = w_head.wen && (w_head.rd != '0);
      rf_rd    = w_head.rd;
      rf_wdata = w_head.data;
    end
  end

  // Pointer and entry state: flush over writeback/retire/alloc; alloc applied last
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head <= '0;
      r_tail <= '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_entry[e] <= '0;
      end
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_entry[e].valid <= 1'b0;
        r_entry[e].ready <= 1'b0;
`ifdef CB_EXCEPTION_EN
        r_entry[e].exc   <= 1'b0;
`endif
      end
    end else begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        if (w_wb_hit[e] && r_entry[e].valid) begin
          r_entry[e].ready <= 1'b1;
          r_entry[e].data  <= w_wb_data[e];
`ifdef CB_EXCEPTION_EN
          r_entry[e].exc   <= w_wb_exc[e];
`endif
        end
      end
      if (w_retire) begin
        r_entry[w_head_idx].valid <= 1'b0;
        r_entry[w_head_idx].ready <= 1'b0;
        r_head                    <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_entry[w_tail_idx].valid <= 1'b1;
        r_entry[w_tail_idx].ready <= 1'b0;
        r_entry[w_tail_idx].wen   <= alloc_wen;
        r_entry[w_tail_idx].rd    <= alloc_rd;
`ifdef CB_EXCEPTION_EN
        r_entry[w_tail_idx].exc   <= 1'b0;
`endif
        r_tail                    <= r_tail + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_completion_buffer.sv
// Directed bench for completion_buffer: expected retirements queued at writeback time,
// a negedge monitor pops and compares every retiring entry.
module tb_completion_buffer;
  import completion_buffer_pkg::*;

  localparam int unsigned IDX_W = CB_IDX_W;

  logic                         CLK;
  logic                         RST;
  logic                         flush;
  logic                         alloc_valid;
  logic [RD_W-1:0]              alloc_rd;
  logic                         alloc_wen;
  logic [IDX_W-1:0]             alloc_index;
  logic                         cb_full;
  logic                         cb_empty;
  logic [IDX_W:0]               cb_count;
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB-1:0][IDX_W-1:0] wb_index;
  logic [NUM_WB-1:0][XLEN-1:0]  wb_data;
`ifdef CB_EXCEPTION_EN
  logic [NUM_WB-1:0]            wb_exception;
  logic                         exc_valid;
  logic [IDX_W-1:0]             exc_index;
`endif
  logic                         rf_wen;
  logic [RD_W-1:0]              rf_rd;
  logic [XLEN-1:0]              rf_wdata;
  logic                         retire_valid;

  typedef struct {
    logic            wen;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  completion_buffer dut (
    .CLK          (CLK),
    .RST          (RST),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .alloc_wen    (alloc_wen),
    .alloc_index  (alloc_index),
    .cb_full      (cb_full),
    .cb_empty     (cb_empty),
    .cb_count     (cb_count),
    .wb_valid     (wb_valid),
    .wb_index     (wb_index),
    .wb_data      (wb_data),
`ifdef CB_EXCEPTION_EN
    .wb_exception (wb_exception),
    .exc_valid    (exc_valid),
    .exc_index    (exc_index),
`endif
    .rf_wen       (rf_wen),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .retire_valid (retire_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Retire monitor: every retiring entry must match the oldest queued expectation
  always @(negedge CLK) begin
    if (!RST && retire_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_retire: got rd=%0d data=0x%0h, expected no retire (t=%0t)",
                 rf_rd, rf_wdata, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("retire_rf_wen", 32'(rf_wen), 32'(e.wen));
        chk("retire_rf_rd", 32'(rf_rd), 32'(e.rd));
        chk("retire_rf_wdata", rf_wdata, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic clear_in();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    alloc_wen   = 1'b0;
    wb_valid    = '0;
    wb_index    = '0;
    wb_data     = '0;
`ifdef CB_EXCEPTION_EN
    wb_exception = '0;
`endif
  endtask

  task automatic do_alloc(input int rd, input logic wen);
    alloc_valid = 1'b1;
    alloc_rd    = RD_W'(rd);
    alloc_wen   = wen;
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input scalar_fu_t fu, input int idx, input logic [31:0] data);
    wb_valid[fu] = 1'b1;
    wb_index[fu] = IDX_W'(idx);
    wb_data[fu]  = data;
  endtask

  task automatic do_wb(input scalar_fu_t fu, input int idx, input logic [31:0] data);
    set_wb(fu, idx, data);
    cyc();
    wb_valid = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic push_exp(input logic wen, input int rd, input logic [31:0] data);
    exp_t e;
    e.wen  = wen;
    e.rd   = RD_W'(rd);
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    RST = 1'b1;
    clear_in();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state
    mid();
    chk("rst_empty", 32'(cb_empty), 32'd1);
    chk("rst_full", 32'(cb_full), 32'd0);
    chk("rst_count", 32'(cb_count), 32'd0);
    chk("rst_alloc_index", 32'(alloc_index), 32'd0);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    cyc();

    // 1: fill all 16 entries, 17th allocation dropped
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = RD_W'(i + 1);
      alloc_wen   = 1'b1;
      mid();
      chk("fill_alloc_index", 32'(alloc_index), 32'(i));
      cyc();
    end
    alloc_valid = 1'b0;
    mid();
    chk("fill_full", 32'(cb_full), 32'd1);
    chk("fill_count", 32'(cb_count), 32'd16);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd31;
    cyc();
    alloc_valid = 1'b0;
    mid();
    chk("drop_count", 32'(cb_count), 32'd16);
    chk("drop_alloc_index", 32'(alloc_index), 32'd0);
    do_flush();
    mid();
    chk("flush1_count", 32'(cb_count), 32'd0);
    chk("flush1_empty", 32'(cb_empty), 32'd1);

    // 2: out-of-order writeback, in-order retire
    do_alloc(5, 1'b1);
    do_alloc(6, 1'b1);
    push_exp(1'b1, 5, 32'h55);
    push_exp(1'b1, 6, 32'hAA);
    do_wb(ARITH_S, 1, 32'hAA);
    mid();
    chk("ooo_no_retire", 32'(retire_valid), 32'd0);
    do_wb(MUL_S, 0, 32'h55);
    repeat (3) cyc();
    mid();
    chk("ooo_count", 32'(cb_count), 32'd0);

    // 3: rd=0 retires without a register write; wen=0 retires without write; no bypass
    do_alloc(0, 1'b1);
    push_exp(1'b0, 0, 32'h1234);
    set_wb(DIV_S, 2, 32'h1234);
    mid();
    chk("no_bypass", 32'(retire_valid), 32'd0);
    cyc();
    wb_valid = '0;
    do_alloc(7, 1'b0);
    push_exp(1'b0, 7, 32'hBEEF);
    do_wb(LOADSTORE_S, 3, 32'hBEEF);
    repeat (2) cyc();
    do_flush();

    // 4: full buffer refuses alloc in a retiring cycle, accepts it next cycle at wrapped index
    for (int i = 0; i < 16; i++) do_alloc(i + 1, 1'b1);
    push_exp(1'b1, 1, 32'h100);
    do_wb(DIV_S, 0, 32'h100);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd20;
    alloc_wen   = 1'b1;
    mid();
    chk("wrap_retire_now", 32'(retire_valid), 32'd1);
    chk("wrap_full_refuse", 32'(cb_full), 32'd1);
    chk("wrap_count_before", 32'(cb_count), 32'd16);
    cyc();
    mid();
    chk("wrap_not_full", 32'(cb_full), 32'd0);
    chk("wrap_alloc_index", 32'(alloc_index), 32'd0);
    chk("wrap_count_mid", 32'(cb_count), 32'd15);
    cyc();
    alloc_valid = 1'b0;
    mid();
    chk("wrap_count_after", 32'(cb_count), 32'd16);
    chk("wrap_full_again", 32'(cb_full), 32'd1);
    chk("wrap_alloc_index_after", 32'(alloc_index), 32'd1);
    do_flush();

    // 5: ARITH and LOADSTORE collide on idx3; ARITH data must win
    for (int i = 0; i < 4; i++) do_alloc(10 + i, 1'b1);
    set_wb(ARITH_S, 3, 32'h1);
    set_wb(LOADSTORE_S, 3, 32'h2);
    cyc();
    wb_valid = '0;
    push_exp(1'b1, 10, 32'hA0);
    push_exp(1'b1, 11, 32'hA1);
    push_exp(1'b1, 12, 32'hA2);
    push_exp(1'b1, 13, 32'h1);
    set_wb(ARITH_S, 0, 32'hA0);
    set_wb(MUL_S, 1, 32'hA1);
    set_wb(DIV_S, 2, 32'hA2);
    cyc();
    wb_valid = '0;
    repeat (5) cyc();
    mid();
    chk("collide_count", 32'(cb_count), 32'd0);
    do_flush();

    // 6: flush with 5 entries, a ready head and writeback/alloc asserted
    for (int i = 0; i < 5; i++) do_alloc(i + 1, 1'b1);
    do_wb(ARITH_S, 0, 32'h77);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    alloc_wen   = 1'b1;
    set_wb(MUL_S, 1, 32'h88);
    mid();
    chk("flush_retire_valid", 32'(retire_valid), 32'd0);
    chk("flush_rf_wen", 32'(rf_wen), 32'd0);
    chk("flush_rf_wdata", rf_wdata, 32'd0);
    cyc();
    clear_in();
    mid();
    chk("flush_count", 32'(cb_count), 32'd0);
    chk("flush_empty", 32'(cb_empty), 32'd1);
    chk("flush_alloc_index", 32'(alloc_index), 32'd0);
    repeat (3) cyc();

    // 7: asynchronous reset mid-operation discards entries
    do_alloc(3, 1'b1);
    do_alloc(4, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("async_rst_count", 32'(cb_count), 32'd0);
    chk("async_rst_empty", 32'(cb_empty), 32'd1);
    chk("async_rst_retire", 32'(retire_valid), 32'd0);
    cyc();
    RST = 1'b0;
    mid();
    chk("post_rst_alloc_index", 32'(alloc_index), 32'd0);
    cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
